// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
// Two-channel soft-start PWM driver for the line-follower H-bridges.
// Each channel ramps its duty toward MAX_DUTY while commanded on and back
// to zero when released. The ramp advances one RAMP_STEP per prescaler tick.
// Both channels share one free-running PWM counter. Their outputs are registered.
module motor_pwm_driver #(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_DIV  = 16,
    parameter int RAMP_STEP = 8,
    parameter int MAX_DUTY  = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                motorLeft,
    input  logic                motorRight,
    output logic                pwmLeft,
    output logic                pwmRight,
    output logic [PWM_BITS-1:0] dutyLeft,
    output logic [PWM_BITS-1:0] dutyRight,
    output logic                ramping
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    // Duty arithmetic is done one bit wider so the ramp-up sum cannot wrap.
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(RAMP_STEP);
    localparam logic [PWM_BITS:0]   MAX_EXT  = (PWM_BITS + 1)'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] MAX_VAL  = MAX_EXT[PWM_BITS-1:0];

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_RAMP_UP   = 2'b01,
        S_RUN       = 2'b10,
        S_RAMP_DOWN = 2'b11
    } state_e;

    // ------------------------------------------------------------------
    // Shared timebase: PWM counter and ramp prescaler
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic                tick;

    assign tick = (presc_q == DIV_LAST);

    // Next counter values. The PWM counter wraps naturally at 2^PWM_BITS.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        presc_d   = tick ? '0 : presc_q + 1'b1;
    end

    // Timebase registers. After reset release the first tick falls on edge RAMP_DIV.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            presc_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel ramp FSM. Index 0 is the left motor and index 1 the right.
    // ------------------------------------------------------------------
    logic [1:0]          cmd_w;
    logic [1:0]          pwm_w;
    logic [1:0]          active_w;
    logic [PWM_BITS-1:0] duty_w [2];

    assign cmd_w = {motorRight, motorLeft};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_e              state_q, state_d;
        logic [PWM_BITS-1:0] duty_q, duty_d;
        logic                pwm_q, pwm_d;
        logic [PWM_BITS:0]   up_sum;
        logic [PWM_BITS-1:0] up_val;
        logic [PWM_BITS-1:0] down_val;

        // Saturating ramp-up value and ramp-down value that floors at zero.
        always_comb begin
            up_sum   = {1'b0, duty_q} + STEP_EXT;
            up_val   = (up_sum > MAX_EXT) ? MAX_VAL : up_sum[PWM_BITS-1:0];
            down_val = ({1'b0, duty_q} < STEP_EXT) ? '0
                     : duty_q - STEP_EXT[PWM_BITS-1:0];
        end

        // Next-state and duty update. The command wins over the end-of-ramp
        // check. Duty follows the current state, even when the state also changes this cycle.
        always_comb begin
            // NOTE: every output of this block gets a default first, so no
            // path through the case can leave a value unassigned and infer a latch.
            state_d = state_q;
            duty_d  = duty_q;
            pwm_d   = (pwm_cnt_q < duty_q);
            case (state_q)
                S_IDLE: begin
                    if (cmd_w[ch]) state_d = S_RAMP_UP;
                end
                S_RAMP_UP: begin
                    if (tick) duty_d = up_val;
                    if (!cmd_w[ch])             state_d = S_RAMP_DOWN;
                    else if (duty_q == MAX_VAL) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!cmd_w[ch]) state_d = S_RAMP_DOWN;
                end
                S_RAMP_DOWN: begin
                    if (tick) duty_d = down_val;
                    if (cmd_w[ch])         state_d = S_RAMP_UP;
                    else if (duty_q == '0) state_d = S_IDLE;
                end
                // Any corrupted encoding returns to IDLE and the duty is held.
                default: state_d = S_IDLE;
            endcase
        end

        // Channel registers. Reset drops the output at once, with no ramp-down.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                duty_q  <= '0;
                pwm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                duty_q  <= duty_d;
                pwm_q   <= pwm_d;
            end
        end

        assign pwm_w[ch]    = pwm_q;
        assign duty_w[ch]   = duty_q;
        assign active_w[ch] = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pwmLeft   = pwm_w[0];
    assign pwmRight  = pwm_w[1];
    assign dutyLeft  = duty_w[0];
    assign dutyRight = duty_w[1];
    assign ramping   = |active_w;

endmodule
